// File: rtl/multi_countdown_timer.sv
// Multi-channel BCD hh:mm:ss countdown timer with a shared 1 s prescaler, pause/resume and load checking.
// Optional TIMER_AUTORELOAD_EN: per-channel reload register, channel reloads and keeps running on reaching zero.
module multi_countdown_timer #(
  parameter int CHANNELS = 2,
  parameter int TICK_DIV = 500000,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SEL_W-1:0]    sel,
  input  logic                write,
  input  logic                start,
  input  logic                stop,
  input  logic [23:0]         set_time,
  output logic [23:0]         get_time,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] complete,
  output logic [CHANNELS-1:0] expired,
  output logic                load_err
);

  // state | meaning: IDLE loaded or never run, RUN counting, PAUSE held by stop, DONE reached zero
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_TOP = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  logic [CHANNELS-1:0][1:0]  state, state_n;
  logic [CHANNELS-1:0][23:0] value, value_n;
  logic [CHANNELS-1:0]       busy_n, complete_n, expired_n;
  logic                      load_err_n;
`ifdef TIMER_AUTORELOAD_EN
  logic [CHANNELS-1:0][23:0] reload_val, reload_val_n;
`endif

  logic        hit, do_tick, do_start;
  logic [23:0] start_val, dec;

  function automatic logic bcd_valid(input logic [23:0] t);
    return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) &&
           (t[15:12] <= 4'd5) && (t[19:16] <= 4'd9) && (t[23:20] <= 4'd9);
  endfunction

  // Caller guarantees a non-zero value, so the borrow never runs off the top digit.
  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [23:0] r;
    logic        borrow;
    logic [3:0]  d;
    logic [3:0]  top;
    r      = t;
    borrow = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d   = t[4*k +: 4];
      top = (k == 1 || k == 3) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*k +: 4] = top;
        end else begin
          r[4*k +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Prescaler counts down; the terminal count is the same cycle an up-counter would hit TICK_DIV-1.
  assign tick = (pre == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= PRE_TOP;
    end else if (tick) begin
      pre <= PRE_TOP;
    end else begin
      pre <= pre - 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    value_n    = value;
    expired_n  = expired;
    complete_n = '0;
    busy_n     = '0;
    load_err_n = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    reload_val_n = reload_val;
`endif
    hit       = 1'b0;
    do_tick   = 1'b0;
    do_start  = 1'b0;
    start_val = '0;
    dec       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit       = (sel == SEL_W'(i));
      do_tick   = 1'b1;
      do_start  = 1'b0;
      start_val = value[i];
      if (hit && write) begin
        // A rejected write swallows any coincident start/stop; the channel keeps counting.
        if (state[i] == S_RUN || !bcd_valid(set_time)) begin
          load_err_n = 1'b1;
        end else begin
          do_tick      = 1'b0;
          value_n[i]   = set_time;
          expired_n[i] = 1'b0;
          state_n[i]   = S_IDLE;
          do_start     = start;
          start_val    = set_time;
`ifdef TIMER_AUTORELOAD_EN
          reload_val_n[i] = set_time;
`endif
        end
      end else if (hit && stop) begin
        do_tick = 1'b0;
        if (state[i] == S_RUN) state_n[i] = S_PAUSE;
      end else if (hit && start && state[i] != S_RUN) begin
        do_tick  = 1'b0;
        do_start = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
        if (state[i] == S_DONE) start_val = reload_val[i];
`endif
      end

      if (do_start) begin
        value_n[i]   = start_val;
        expired_n[i] = 1'b0;
        if (start_val == '0) begin
          state_n[i]    = S_DONE;
          complete_n[i] = 1'b1;
          expired_n[i]  = 1'b1;
        end else begin
          state_n[i] = S_RUN;
        end
      end else if (do_tick && tick && state[i] == S_RUN) begin
        dec        = bcd_dec(value[i]);
        value_n[i] = dec;
        if (dec == '0) begin
          complete_n[i] = 1'b1;
          expired_n[i]  = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
          if (reload_val[i] != '0) value_n[i] = reload_val[i];
          else                     state_n[i] = S_DONE;
`else
          state_n[i] = S_DONE;
`endif
        end
      end
      busy_n[i] = (state_n[i] == S_RUN);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= '0;
      value    <= '0;
      busy     <= '0;
      complete <= '0;
      expired  <= '0;
      load_err <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      reload_val <= '0;
`endif
    end else begin
      state    <= state_n;
      value    <= value_n;
      busy     <= busy_n;
      complete <= complete_n;
      expired  <= expired_n;
      load_err <= load_err_n;
`ifdef TIMER_AUTORELOAD_EN
      reload_val <= reload_val_n;
`endif
    end
  end

  always_comb begin
    get_time = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) get_time = value[i];
    end
  end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Bench for multi_countdown_timer: seconds-based reference model compared every cycle, plus directed literal checks.
module tb_multi_countdown_timer;
  localparam int CH = 2;
  localparam int TD = 4;
  localparam int SW = 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] sel = '0;
  logic          write = 1'b0, start = 1'b0, stop = 1'b0;
  logic [23:0]   set_time = '0;
  logic [23:0]   get_time;
  logic [CH-1:0] busy, complete, expired;
  logic          load_err;

  int vectors = 0;
  int miscompares = 0;

  multi_countdown_timer #(.CHANNELS(CH), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .sel(sel), .write(write), .start(start), .stop(stop),
    .set_time(set_time), .get_time(get_time), .busy(busy), .complete(complete),
    .expired(expired), .load_err(load_err)
  );

  always #5 clock = ~clock;

  // Reference model: remaining time held as plain seconds.
  int m_state[CH];
  int m_sec[CH];
  int m_rld[CH];
  bit m_cmp[CH];
  bit m_exp[CH];
  bit m_err;
  int cyc;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int from_bcd(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic bit time_ok(input logic [23:0] t);
    int hh, mm, ss;
    hh = int'(t[23:20]) * 10 + int'(t[19:16]);
    mm = int'(t[15:12]) * 10 + int'(t[11:8]);
    ss = int'(t[7:4]) * 10 + int'(t[3:0]);
    return t[23:20] < 10 && t[19:16] < 10 && t[11:8] < 10 && t[3:0] < 10 && mm < 60 && ss < 60 && hh < 100;
  endfunction

  task automatic model_go(input int ch);
    m_exp[ch] = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    if (m_state[ch] == M_DONE) m_sec[ch] = m_rld[ch];
`endif
    if (m_sec[ch] == 0) begin
      m_state[ch] = M_DONE;
      m_cmp[ch] = 1'b1;
      m_exp[ch] = 1'b1;
    end else begin
      m_state[ch] = M_RUN;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < CH; ch++) begin
        m_state[ch] = M_IDLE; m_sec[ch] = 0; m_rld[ch] = 0; m_cmp[ch] = 0; m_exp[ch] = 0;
      end
      m_err = 0;
      cyc = 0;
    end else begin
      bit tk;
      tk = (cyc % TD) == TD - 1;
      cyc++;
      m_err = 0;
      for (int ch = 0; ch < CH; ch++) begin
        bit counts;
        counts = 1'b1;
        m_cmp[ch] = 1'b0;
        if (int'(sel) == ch) begin
          if (write) begin
            if (m_state[ch] == M_RUN || !time_ok(set_time)) begin
              m_err = 1'b1;
            end else begin
              counts = 1'b0;
              m_sec[ch] = from_bcd(set_time);
              m_rld[ch] = m_sec[ch];
              m_exp[ch] = 1'b0;
              m_state[ch] = M_IDLE;
              if (start) model_go(ch);
            end
          end else if (stop) begin
            counts = 1'b0;
            if (m_state[ch] == M_RUN) m_state[ch] = M_PAUSE;
          end else if (start && m_state[ch] != M_RUN) begin
            counts = 1'b0;
            model_go(ch);
          end
        end
        if (counts && tk && m_state[ch] == M_RUN) begin
          m_sec[ch]--;
          if (m_sec[ch] == 0) begin
            m_cmp[ch] = 1'b1;
            m_exp[ch] = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
            if (m_rld[ch] != 0) m_sec[ch] = m_rld[ch];
            else m_state[ch] = M_DONE;
`else
            m_state[ch] = M_DONE;
`endif
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [CH-1:0] eb, ec, ee;
    for (int ch = 0; ch < CH; ch++) begin
      eb[ch] = (m_state[ch] == M_RUN);
      ec[ch] = m_cmp[ch];
      ee[ch] = m_exp[ch];
    end
    check("busy", 32'(busy), 32'(eb));
    check("complete", 32'(complete), 32'(ec));
    check("expired", 32'(expired), 32'(ee));
    check("load_err", 32'(load_err), 32'(m_err));
    check("get_time", 32'(get_time), 32'(to_bcd(m_sec[int'(sel)])));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cmd(input int ch, input bit w, input bit s, input bit p, input logic [23:0] t);
    sel = SW'(ch);
    write = w; start = s; stop = p; set_time = t;
    step(1);
    write = 0; start = 0; stop = 0;
  endtask

  task automatic to_phase(input int ph);
    for (int k = 0; k < TD && (cyc % TD) != ph; k++) step(1);
  endtask

  task automatic to_tick_cycle();
    to_phase(TD - 1);
  endtask

  initial begin
    int a, b, pulses;
    bit stayed;
    step(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_time", 32'(get_time), 0);
    check("rst_expired", 32'(expired), 0);
    check("rst_complete", 32'(complete), 0);
    reset = 0;

    // basic countdown from 3 s
    cmd(0, 1, 0, 0, 24'h000003);
    check("t1_load_err", 32'(load_err), 0);
    check("t1_loaded", 32'(get_time), 32'h000003);
    cmd(0, 0, 1, 0, 24'h0);
    check("t1_busy", 32'(busy[0]), 1);
    to_tick_cycle(); step(1);
    check("t1_after1", 32'(get_time), 32'h000002);
    to_tick_cycle(); step(1);
    check("t1_after2", 32'(get_time), 32'h000001);
    to_tick_cycle(); step(1);
    check("t1_complete", 32'(complete[0]), 1);
    check("t1_expired", 32'(expired[0]), 1);
    check("t1_idle", 32'(busy[0]), 0);
    check("t1_zero", 32'(get_time), 0);
    step(1);
    check("t1_pulse_end", 32'(complete[0]), 0);
    check("t1_sticky", 32'(expired[0]), 1);

    // borrow chains
    cmd(0, 1, 0, 0, 24'h010000);
    check("t2_exp_clear", 32'(expired[0]), 0);
    cmd(0, 0, 1, 0, 24'h0);
    to_tick_cycle(); step(1);
    check("t2_borrow_h", 32'(get_time), 32'h005959);
    cmd(0, 0, 0, 1, 24'h0);
    check("t2_paused", 32'(busy[0]), 0);
    cmd(0, 1, 0, 0, 24'h100000);
    cmd(0, 0, 1, 0, 24'h0);
    to_tick_cycle(); step(1);
    check("t2_borrow_h10", 32'(get_time), 32'h095959);
    cmd(0, 0, 0, 1, 24'h0);

    // rejected loads
    cmd(0, 1, 0, 0, 24'h006000);
    check("t3_err_m10", 32'(load_err), 1);
    check("t3_keep_m10", 32'(get_time), 32'h095959);
    cmd(0, 1, 0, 0, 24'h00000A);
    check("t3_err_s1", 32'(load_err), 1);
    check("t3_keep_s1", 32'(get_time), 32'h095959);
    step(1);
    check("t3_err_pulse", 32'(load_err), 0);
    cmd(0, 0, 1, 0, 24'h0);
    cmd(0, 1, 0, 0, 24'h000005);
    check("t3_err_run", 32'(load_err), 1);
    check("t3_still_run", 32'(busy[0]), 1);
    cmd(0, 0, 0, 1, 24'h0);

    // two channels, ch1 held for 3 ticks
    cmd(0, 1, 0, 0, 24'h000100);
    cmd(1, 1, 0, 0, 24'h000100);
    to_phase(0);
    cmd(0, 0, 1, 0, 24'h0);
    cmd(1, 0, 1, 0, 24'h0);
    step(8);
    to_phase(0);
    cmd(1, 0, 0, 1, 24'h0);
    step(11);
    cmd(1, 0, 1, 0, 24'h0);
    step(8);
    sel = 0; #1; a = from_bcd(get_time);
    sel = 1; #1; b = from_bcd(get_time);
    check("t4_lag", 32'(b - a), 3);
    cmd(1, 0, 1, 1, 24'h0);
    check("t4_stop_wins", 32'(busy[1]), 0);
    check("t4_other_runs", 32'(busy[0]), 1);
    cmd(0, 0, 0, 1, 24'h0);

    // start with zero
    cmd(1, 1, 0, 0, 24'h000000);
    cmd(1, 0, 1, 0, 24'h0);
    check("t5_zero_cmp", 32'(complete[1]), 1);
    check("t5_zero_exp", 32'(expired[1]), 1);
    check("t5_zero_busy", 32'(busy[1]), 0);
    step(1);
    check("t5_zero_pulse", 32'(complete[1]), 0);

    // load-and-go, then commands coincident with ticks
    cmd(1, 1, 1, 0, 24'h000004);
    check("t6_go_busy", 32'(busy[1]), 1);
    check("t6_go_exp", 32'(expired[1]), 0);
    check("t6_go_time", 32'(get_time), 32'h000004);
    to_tick_cycle();
    cmd(1, 0, 0, 1, 24'h0);
    check("t6_stop_tick", 32'(get_time), 32'h000004);
    to_tick_cycle();
    cmd(1, 0, 1, 0, 24'h0);
    check("t6_start_tick", 32'(get_time), 32'h000004);
    to_tick_cycle(); step(1);
    check("t6_first_dec", 32'(get_time), 32'h000003);

    // asynchronous reset mid-count
    #2;
    reset = 1;
    #1;
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_time", 32'(get_time), 0);
    check("t7_rst_exp", 32'(expired), 0);
    step(2);
    reset = 0;

`ifdef TIMER_AUTORELOAD_EN
    cmd(0, 1, 0, 0, 24'h000002);
    cmd(0, 0, 1, 0, 24'h0);
    step(1);
    pulses = 0;
    stayed = 1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (complete[0]) pulses++;
      if (!busy[0]) stayed = 0;
    end
    check("t8_reload_pulses", 32'(pulses), 2);
    check("t8_reload_busy", 32'(stayed), 1);
`else
    cmd(0, 1, 0, 0, 24'h000002);
    cmd(0, 0, 1, 0, 24'h0);
    step(1);
    pulses = 0;
    stayed = 1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (complete[0]) pulses++;
      if (!busy[0]) stayed = 0;
    end
    check("t8_single_pulse", 32'(pulses), 1);
    check("t8_stops", 32'(stayed), 0);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/multi_countdown_timer.md
# multi_countdown_timer

Parametrised multi-channel BCD countdown timer, successor to the single-channel HH:MM:SS countdown register. Holds CHANNELS independent hh:mm:ss counters sharing one internal tick prescaler, adds pause/resume, per-channel completion pulses, sticky expiry flags and load validation. Sits between the front-panel/keypad controller (set, start, stop) and the 7-segment display driver (readback).

## Interface
- CHANNELS, 2, number of independent timer channels (1..8)
- TICK_DIV, 500000, clock cycles per 1 s tick (≥2)
- SEL_W, $clog2(CHANNELS) (min 1), width of sel

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sel  in  SEL_W  channel addressed by write/start/stop and by get_time
- write  in  1  one-cycle strobe: load set_time into channel sel
- start  in  1  one-cycle strobe: run/resume channel sel
- stop  in  1  one-cycle strobe: pause channel sel
- set_time  in  24  BCD {H10,H1,M10,M1,S10,S1}, 4 bits each, H10 is MSBs
- get_time  out  24  current value of channel sel, same packing, combinational from state registers
- busy  out  CHANNELS  bit i = channel i in RUN
- complete  out  CHANNELS  bit i pulses one cycle when channel i reaches 00:00:00
- expired  out  CHANNELS  bit i sticky, set with complete[i], cleared by write or start to channel i
- load_err  out  1  one-cycle pulse when a write is rejected

## Operation
- Per-channel FSM: IDLE, RUN, PAUSE, DONE. Reset: all IDLE, all digits 0, busy/complete/expired/load_err = 0.
- Prescaler: free-running counter 0..TICK_DIV-1 from reset; tick = 1 for one cycle when count = TICK_DIV-1. Shared; not restarted by start.
- write (channel not RUN, set_time valid): load digits, state → IDLE, clear expired. Valid: every digit ≤9, S10 ≤5, M10 ≤5. Invalid digit or channel in RUN: channel unchanged, load_err pulses.
- start: IDLE/PAUSE/DONE → RUN if value ≠ 0; value = 0 → DONE, complete + expired set. Clears expired first. Ignored in RUN.
- stop: RUN → PAUSE, value held. Ignored in other states.
- RUN on tick: BCD decrement with borrow chain S1 (9→0), S10 (5→0), M1 (9→0), M10 (5→0), H1 (9→0), H10 (9→0). Max 99:59:59. Decrement yielding 00:00:00 → DONE, complete/expired set.
- Simultaneous, same channel: write+start → load then RUN (load-and-go; rejected write also cancels start); stop+start → stop wins; write+stop → write (stop ignored). Commands address only sel; other channels keep counting on tick.

## Timing
- All state, digit, busy, complete, expired, load_err updates on clock rising edge; outputs registered except get_time.
- Command strobe in cycle n → state/busy visible cycle n+1; complete/load_err high during cycle n+1 only.
- Tick in cycle n that reaches zero → digits 0, busy low, complete high in cycle n+1.
- Command coincident with tick: start does not consume that tick (first decrement on next tick); stop in the tick cycle wins, no decrement.
- reset asserted mid-count: immediate (asynchronous) return to reset values, prescaler to 0.

## Configuration
- TIMER_AUTORELOAD_EN defined: each channel keeps a 24-bit reload register written by every accepted write; on reaching zero in RUN, complete/expired pulse/set as normal but digits reload and channel stays RUN (reload value 0 → DONE). Start from DONE reloads first.
- Undefined: no reload registers; zero → DONE as above.

## Test plan
- TICK_DIV=4, CHANNELS=2: write 00:00:03 to ch0, start -> busy[0]=1, get_time decrements every 4 cycles, complete[0] pulse one cycle after third tick, expired[0]=1, busy[0]=0.
- Borrow: load 01:00:00, start, one tick -> 00:59:59; load 10:00:00 -> 09:59:59.
- write 00:60:00 or S1=0xA -> load_err pulse, value unchanged; write during RUN -> load_err, count continues.
- ch0 and ch1 running, stop ch1 for 3 ticks, start -> ch1 lags ch0 by exactly 3 s; stop+start same cycle -> PAUSE.
- start with 00:00:00 -> DONE and complete next cycle; reset mid-count -> all outputs 0 immediately.
- TIMER_AUTORELOAD_EN: load 00:00:02, start -> complete pulses every 2 ticks, busy stays 1.
